// File: rtl/and_arb.sv
// Two-requester round-robin front end for a shared registered AND unit with fixed latency UNIT_LAT.
// Define AND_ARB_SVA_EN to compile in the protocol assertions.
module and_arb #(
  parameter int DW       = 8,
  parameter int UNIT_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  output logic          req1_ready,
  output logic [DW-1:0] unit_a,
  output logic [DW-1:0] unit_b,
  input  logic [DW-1:0] unit_y,
  output logic          rsp_valid,
  output logic          rsp_id,
  output logic [DW-1:0] rsp_y,
  input  logic          rsp_ready
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state_reg, state_next;
  logic [3:0]    cnt_reg;
  logic          last_grant_reg;
  logic          gnt_valid;
  logic          gnt_id;
  logic          accept;
  logic          wait_done;

  // Round-robin: on a tie the requester that did not win last time is chosen.
  always_comb begin
    gnt_valid = req0_valid | req1_valid;
    gnt_id    = 1'b0;
    if (req0_valid && req1_valid) begin
      gnt_id = ~last_grant_reg;
    end else if (req1_valid) begin
      gnt_id = 1'b1;
    end
  end

  assign wait_done = (cnt_reg == 4'd0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (gnt_valid) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (wait_done) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode; ready is masked by rst_n so nothing is offered during reset.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;
    accept     = 1'b0;
    if (state_reg == IDLE && rst_n && gnt_valid) begin
      accept     = 1'b1;
      req0_ready = ~gnt_id;
      req1_ready = gnt_id;
    end
    if (state_reg == RESP) begin
      rsp_valid = 1'b1;
    end
  end

  // Datapath: operand capture, latency counter and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      unit_a         <= '0;
      unit_b         <= '0;
      rsp_id         <= 1'b0;
      rsp_y          <= '0;
      cnt_reg        <= 4'd0;
      last_grant_reg <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            unit_a         <= gnt_id ? req1_a : req0_a;
            unit_b         <= gnt_id ? req1_b : req0_b;
            rsp_id         <= gnt_id;
            last_grant_reg <= gnt_id;
          end
        end
        ISSUE: begin
          cnt_reg <= 4'(UNIT_LAT - 1);
        end
        WAIT: begin
          if (wait_done) begin
            rsp_y <= unit_y;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef AND_ARB_SVA_EN
  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    !(req0_ready && req1_ready))
    else $display("%0t and_arb ready not one-hot: r0=%b r1=%b", $time, req0_ready, req1_ready);

  a_rsp_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (rsp_valid && !rsp_ready) |=> ($stable(rsp_y) && $stable(rsp_id)))
    else $display("%0t and_arb rsp unstable: y=%h id=%b", $time, rsp_y, rsp_id);

  a_unit_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (state_reg == WAIT) |-> ($stable(unit_a) && $stable(unit_b)))
    else $display("%0t and_arb operands moved: a=%h b=%h", $time, unit_a, unit_b);

  a_latency: assert property (@(posedge clk) disable iff (!rst_n)
    accept |-> ##(UNIT_LAT + 2) rsp_valid)
    else $display("%0t and_arb late response: rsp_valid=%b", $time, rsp_valid);
`endif

endmodule
